mem_access_stage: RTL and testbench

//  Memory-access stage of the 64-bit sequential RV64 core. It sits between execute and writeback.
//  It issues loads and stores to data memory over a req/ack handshake.
//  It aligns and extends load data, and presents ReadData, ALUResult, Rd, MemtoReg and RegWrite
//  to writeback with a one-cycle wb_valid pulse.

---
 rtl/mem_access_stage.sv | 246 ++++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// Memory-access stage of the sequential RV64 core.
// Latches execute results on start and issues at most one data-memory access
// over a req/ack handshake. Load data is aligned and extended before it goes
// to writeback. Results are presented with a single-cycle wb_valid pulse.
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] ALUResult,
  input  logic [63:0] StoreData,
  input  logic [4:0]  Rd,
  input  logic [2:0]  Funct3,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemtoReg,
  input  logic        RegWrite,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic        busy,
  output logic        wb_valid,
  output logic [63:0] ReadData,
  output logic [63:0] ALUResultOut,
  output logic [4:0]  RdOut,
  output logic        MemtoRegOut,
  output logic        RegWriteOut,
  output logic        fault
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE_C = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ZERO_C = {CW{1'b0}};

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_e;

  state_e          state_r;
  state_e          nextState_s;
  logic [CW-1:0]   cnt_r;
  logic [2:0]      funct3_r;
  logic [2:0]      addrLow_r;
  logic            isLoad_r;

  logic            isLoad_s;
  logic            isStore_s;
  logic            illegal_s;
  logic            misaligned_s;
  logic            startFault_s;
  logic            goAccess_s;
  logic            accept_s;
  logic            timeoutHit_s;
  logic            finish_s;

  // Byte-enable pattern for a store of the given size at the given byte offset.
  function automatic logic [7:0] storeStrobe(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] base;
    case (size)
      2'b00:   base = 8'h01;
      2'b01:   base = 8'h03;
      2'b10:   base = 8'h0F;
      2'b11:   base = 8'hFF;
      default: base = 8'h00;
    endcase
    return base << off;
  endfunction

  // Pull the addressed bytes out of the doubleword and sign/zero-extend them.
  function automatic logic [63:0] extendLoad(input logic [63:0] rdata, input logic [2:0] off,
                                             input logic [2:0] f3);
    logic [63:0] sh;
    logic [63:0] res;
    sh = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  res = {{56{sh[7]}}, sh[7:0]};
      3'b001:  res = {{48{sh[15]}}, sh[15:0]};
      3'b010:  res = {{32{sh[31]}}, sh[31:0]};
      3'b011:  res = sh;
      3'b100:  res = {56'h0, sh[7:0]};
      3'b101:  res = {48'h0, sh[15:0]};
      3'b110:  res = {32'h0, sh[31:0]};
      default: res = 64'h0;
    endcase
    return res;
  endfunction

  // Classify the incoming operation and decide whether it needs the bus.
  always_comb begin
    isLoad_s     = MemRead & ~MemWrite;
    isStore_s    = MemWrite & ~MemRead;
    illegal_s    = 1'b0;
    misaligned_s = 1'b0;
    if (isLoad_s) begin
      illegal_s = (Funct3 == 3'b111);
    end else if (isStore_s) begin
      illegal_s = Funct3[2];
    end else begin
      illegal_s = 1'b0;
    end
    case (Funct3[1:0])
      2'b00:   misaligned_s = 1'b0;
      2'b01:   misaligned_s = ALUResult[0];
      2'b10:   misaligned_s = (ALUResult[1:0] != 2'b00);
      2'b11:   misaligned_s = (ALUResult[2:0] != 3'b000);
      default: misaligned_s = 1'b0;
    endcase
    startFault_s = (MemRead & MemWrite) |
                   ((isLoad_s | isStore_s) & (illegal_s | misaligned_s));
    accept_s     = start & (state_r == IDLE);
    goAccess_s   = accept_s & (isLoad_s | isStore_s) & ~startFault_s;
    timeoutHit_s = (cnt_r == TIMEOUT_C);
    finish_s     = mem_ack | timeoutHit_s;
  end

  // Next-state logic: an accepted start goes to ACCESS only for a clean mem op.
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          nextState_s = goAccess_s ? ACCESS : DONE;
        end else begin
          nextState_s = IDLE;
        end
      end
      ACCESS: begin
        if (finish_s) begin
          nextState_s = DONE;
        end else begin
          nextState_s = ACCESS;
        end
      end
      DONE:    nextState_s = IDLE;
      default: nextState_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Counts cycles spent in ACCESS; starts at 1 so it equals TIMEOUT on the last allowed cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= CNT_ZERO_C;
    end else if (goAccess_s) begin
      cnt_r <= CNT_ONE_C;
    end else if ((state_r == ACCESS) && !finish_s) begin
      cnt_r <= cnt_r + CNT_ONE_C;
    end else begin
      cnt_r <= CNT_ZERO_C;
    end
  end

  // Registered datapath: latch operands, drive the bus, capture load data, pulse writeback.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 64'h0;
      mem_wdata    <= 64'h0;
      mem_wstrb    <= 8'h00;
      busy         <= 1'b0;
      wb_valid     <= 1'b0;
      ReadData     <= 64'h0;
      ALUResultOut <= 64'h0;
      RdOut        <= 5'd0;
      MemtoRegOut  <= 1'b0;
      RegWriteOut  <= 1'b0;
      fault        <= 1'b0;
      funct3_r     <= 3'b000;
      addrLow_r    <= 3'b000;
      isLoad_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          wb_valid <= 1'b0;
          if (accept_s) begin
            busy         <= 1'b1;
            ALUResultOut <= ALUResult;
            RdOut        <= Rd;
            MemtoRegOut  <= MemtoReg;
            RegWriteOut  <= RegWrite & ~startFault_s;
            fault        <= startFault_s;
            ReadData     <= 64'h0;
            funct3_r     <= Funct3;
            addrLow_r    <= ALUResult[2:0];
            isLoad_r     <= isLoad_s;
            // A faulting or passthrough op goes straight to writeback.
            wb_valid     <= ~goAccess_s;
            if (goAccess_s) begin
              mem_req   <= 1'b1;
              mem_we    <= isStore_s;
              mem_addr  <= {ALUResult[63:3], 3'b000};
              mem_wdata <= isStore_s ? (StoreData << {ALUResult[2:0], 3'b000}) : 64'h0;
              mem_wstrb <= isStore_s ? storeStrobe(Funct3[1:0], ALUResult[2:0]) : 8'h00;
            end
          end
        end
        ACCESS: begin
          if (finish_s) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 64'h0;
            mem_wdata <= 64'h0;
            mem_wstrb <= 8'h00;
            wb_valid  <= 1'b1;
            // An ack on the timeout cycle still counts as a completed access.
            if (mem_ack) begin
              if (isLoad_r) begin
                ReadData <= extendLoad(mem_rdata, addrLow_r, funct3_r);
              end
            end else begin
              fault       <= 1'b1;
              RegWriteOut <= 1'b0;
            end
          end
        end
        DONE: begin
          wb_valid <= 1'b0;
          busy     <= 1'b0;
        end
        default: begin
          wb_valid <= 1'b0;
          busy     <= 1'b0;
          mem_req  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios followed by
// randomized transactions checked against a byte-level reference model.
module tb_mem_access_stage;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [63:0] ALUResult;
  logic [63:0] StoreData;
  logic [4:0]  Rd;
  logic [2:0]  Funct3;
  logic        MemRead;
  logic        MemWrite;
  logic        MemtoReg;
  logic        RegWrite;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        busy;
  logic        wb_valid;
  logic [63:0] ReadData;
  logic [63:0] ALUResultOut;
  logic [4:0]  RdOut;
  logic        MemtoRegOut;
  logic        RegWriteOut;
  logic        fault;

  int vectors = 0;
  int miscompares = 0;

  mem_access_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ALUResult(ALUResult), .StoreData(StoreData),
    .Rd(Rd), .Funct3(Funct3), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .wb_valid(wb_valid), .ReadData(ReadData), .ALUResultOut(ALUResultOut),
    .RdOut(RdOut), .MemtoRegOut(MemtoRegOut), .RegWriteOut(RegWriteOut), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    chk({tag, ".mem_req"},      {63'h0, mem_req},     64'h0);
    chk({tag, ".mem_we"},       {63'h0, mem_we},      64'h0);
    chk({tag, ".mem_addr"},     mem_addr,             64'h0);
    chk({tag, ".mem_wdata"},    mem_wdata,            64'h0);
    chk({tag, ".mem_wstrb"},    {56'h0, mem_wstrb},   64'h0);
    chk({tag, ".busy"},         {63'h0, busy},        64'h0);
    chk({tag, ".wb_valid"},     {63'h0, wb_valid},    64'h0);
    chk({tag, ".ReadData"},     ReadData,             64'h0);
    chk({tag, ".ALUResultOut"}, ALUResultOut,         64'h0);
    chk({tag, ".RdOut"},        {59'h0, RdOut},       64'h0);
    chk({tag, ".MemtoRegOut"},  {63'h0, MemtoRegOut}, 64'h0);
    chk({tag, ".RegWriteOut"},  {63'h0, RegWriteOut}, 64'h0);
    chk({tag, ".fault"},        {63'h0, fault},       64'h0);
  endtask

  // Scribble on the inputs with start high; used to show busy-time starts are ignored.
  task automatic junkStart();
    start     = 1'b1;
    ALUResult = {$urandom, $urandom};
    StoreData = {$urandom, $urandom};
    Rd        = 5'($urandom);
    Funct3    = 3'($urandom);
    MemRead   = 1'($urandom);
    MemWrite  = 1'($urandom);
    MemtoReg  = 1'($urandom);
    RegWrite  = 1'($urandom);
  endtask

  // One complete transaction. ackDelay = cycle of mem_req on which ack is given;
  // a value above TO means ack never comes.
  task automatic doTxn(input string tag, input bit mr, input bit mw, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] sdata, input logic [4:0] rd,
                       input bit m2r, input bit rw, input int ackDelay,
                       input logic [63:0] rdata, input bit junk);
    bit          isLd, isSt, memOp, illegal, misal, flt, acked;
    int          nbytes, off;
    logic [63:0] mask, val, expRd;
    logic [7:0]  expStrb;

    // Reference model: plain byte arithmetic on the access description.
    isLd    = mr && !mw;
    isSt    = mw && !mr;
    memOp   = isLd || isSt;
    nbytes  = 1 << int'(f3[1:0]);
    off     = int'(addr[2:0]);
    illegal = (isLd && f3 == 3'd7) || (isSt && f3 >= 3'd4);
    misal   = memOp && ((off % nbytes) != 0);
    flt     = (mr && mw) || (memOp && (illegal || misal));
    expStrb = 8'(((1 << nbytes) - 1) << off);
    val     = rdata >> (8 * off);
    if (nbytes < 8) begin
      mask = (64'd1 << (8 * nbytes)) - 64'd1;
      val  = val & mask;
      if (f3 < 3'd4 && val[8 * nbytes - 1]) val = val | ~mask;
    end

    MemRead = mr; MemWrite = mw; Funct3 = f3; ALUResult = addr; StoreData = sdata;
    Rd = rd; MemtoReg = m2r; RegWrite = rw; start = 1'b1;
    tick();
    start = 1'b0;
    acked = 1'b0;

    if (memOp && !flt) begin
      for (int c = 1; c <= TO; c++) begin
        chk({tag, ".req"},  {63'h0, mem_req},  64'h1);
        chk({tag, ".addr"}, mem_addr,          {addr[63:3], 3'b000});
        chk({tag, ".we"},   {63'h0, mem_we},   {63'h0, isSt});
        chk({tag, ".busy"}, {63'h0, busy},     64'h1);
        chk({tag, ".wbv0"}, {63'h0, wb_valid}, 64'h0);
        if (isSt) begin
          chk({tag, ".wdata"}, mem_wdata,          sdata << (8 * off));
          chk({tag, ".wstrb"}, {56'h0, mem_wstrb}, {56'h0, expStrb});
        end
        if (junk && c == 1) junkStart();
        if (c == ackDelay) begin
          mem_ack = 1'b1;
          mem_rdata = rdata;
          acked = 1'b1;
        end
        tick();
        start = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = {$urandom, $urandom};
        if (acked) break;
      end
      if (!acked) flt = 1'b1;
    end else begin
      chk({tag, ".noreq"}, {63'h0, mem_req}, 64'h0);
    end

    expRd = (isLd && !flt) ? val : 64'h0;
    chk({tag, ".wbv"},     {63'h0, wb_valid},    64'h1);
    chk({tag, ".busyWb"},  {63'h0, busy},        64'h1);
    chk({tag, ".reqWb"},   {63'h0, mem_req},     64'h0);
    chk({tag, ".strbWb"},  {56'h0, mem_wstrb},   64'h0);
    chk({tag, ".fault"},   {63'h0, fault},       {63'h0, flt});
    chk({tag, ".rw"},      {63'h0, RegWriteOut}, {63'h0, (rw && !flt)});
    chk({tag, ".rdata"},   ReadData,             expRd);
    chk({tag, ".alu"},     ALUResultOut,         addr);
    chk({tag, ".rd"},      {59'h0, RdOut},       {59'h0, rd});
    chk({tag, ".m2r"},     {63'h0, MemtoRegOut}, {63'h0, m2r});

    if (junk) junkStart();
    tick();
    start = 1'b0;
    chk({tag, ".wbvEnd"},  {63'h0, wb_valid}, 64'h0);
    chk({tag, ".busyEnd"}, {63'h0, busy},     64'h0);
    chk({tag, ".reqEnd"},  {63'h0, mem_req},  64'h0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; ALUResult = 64'h0; StoreData = 64'h0; Rd = 5'd0;
    Funct3 = 3'd0; MemRead = 1'b0; MemWrite = 1'b0; MemtoReg = 1'b0; RegWrite = 1'b0;
    mem_ack = 1'b0; mem_rdata = 64'h0;
    repeat (3) tick();
    checkAllZero("reset");
    rst_n = 1'b1;
    tick();

    // Passthrough.
    doTxn("pass", 1'b0, 1'b0, 3'd0, 64'hBBBB_BBBB_BBBB_BBBB, 64'h0, 5'd7, 1'b0, 1'b1, 1, 64'h0, 1'b0);
    // LB / LBU at byte offset 3, ack on third request cycle.
    doTxn("lb",  1'b1, 1'b0, 3'd0, 64'h1003, 64'h0, 5'd3, 1'b1, 1'b1, 3, 64'h0000_0000_8000_0000, 1'b0);
    doTxn("lbu", 1'b1, 1'b0, 3'd4, 64'h1003, 64'h0, 5'd3, 1'b1, 1'b1, 3, 64'h0000_0000_8000_0000, 1'b0);
    // SH in the top halfword.
    doTxn("sh",  1'b0, 1'b1, 3'd1, 64'h2006, 64'hBEEF, 5'd0, 1'b0, 1'b0, 2, 64'h0, 1'b0);
    // Misaligned LW and illegal load encoding.
    doTxn("lwMis", 1'b1, 1'b0, 3'd2, 64'h2002, 64'h0, 5'd9, 1'b1, 1'b1, 1, 64'h0, 1'b0);
    doTxn("ld111", 1'b1, 1'b0, 3'd7, 64'h2000, 64'h0, 5'd9, 1'b1, 1'b1, 1, 64'h0, 1'b0);
    doTxn("both",  1'b1, 1'b1, 3'd3, 64'h2000, 64'h0, 5'd9, 1'b1, 1'b1, 1, 64'h0, 1'b0);
    // Timeout, then ack on the final allowed cycle.
    doTxn("ldTo",   1'b1, 1'b0, 3'd3, 64'h3000, 64'h0, 5'd4, 1'b1, 1'b1, TO + 1, 64'h0, 1'b0);
    doTxn("ldLast", 1'b1, 1'b0, 3'd3, 64'h3008, 64'h0, 5'd4, 1'b1, 1'b1, TO, 64'h1234_5678_9ABC_DEF0, 1'b0);
    // Starts during busy and wb_valid are ignored.
    doTxn("busyStart", 1'b1, 1'b0, 3'd5, 64'h4002, 64'h0, 5'd11, 1'b1, 1'b1, 4, 64'hFFFF_8001_0000_0000, 1'b1);

    // Reset in the middle of an access.
    MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'd3; ALUResult = 64'h5000; Rd = 5'd5;
    RegWrite = 1'b1; MemtoReg = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("midRst.reqBefore", {63'h0, mem_req}, 64'h1);
    rst_n = 1'b0;
    tick();
    checkAllZero("midRst");
    rst_n = 1'b1;
    tick();
    chk("midRst.idle", {63'h0, busy}, 64'h0);

    // Randomized transactions.
    for (int t = 0; t < 80; t++) begin
      logic [63:0] a;
      logic [2:0]  f;
      bit          r, w;
      int          sel;
      sel = int'($urandom_range(0, 9));
      r   = (sel < 5) || (sel == 9);
      w   = (sel >= 5 && sel < 8) || (sel == 9);
      f   = 3'($urandom);
      a   = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << int'(f[1:0])) - 64'd1);
      doTxn("rand", r, w, f, a, {$urandom, $urandom}, 5'($urandom), 1'($urandom), 1'($urandom),
            int'($urandom_range(1, TO + 2)), {$urandom, $urandom}, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
